mem_dump_unit: RTL and testbench
================================

Name: mem_dump_unit

Overview:
- Debug-side sequencer that sits directly upstream of the MEM stage's debug port and consumes that port's outputs.
- On request from the debug controller, it walks every data-memory address, reading through the MEM debug mux. Only the pipeline's halted state makes this safe.
- Each dirty word (written since reset) is serialised as a 5-byte frame to the UART TX. The dump closes with a terminator byte.
- Clean words are skipped, so the host receives only memory the program touched.

Parameters:
- NB_DATA, 32, data word width; must be 32.
- NB_ADDR, `ADDRWIDTH, data-memory address width; must be ≤7 so 0xFF never collides with an address byte.
- NB_BYTE, 8, UART byte width.
- END_BYTE, 8'hFF, terminator byte sent after the last frame.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to begin a dump; ignored unless idle.
- addr_mem_debug_unit_o  out  NB_ADDR  address driven into the MEM debug mux.
- cntl_addr_debug_mem_o  out  1  1 = MEM uses the debug address instead of the ALU result.
- cntl_wr_debug_mem_o  out  1  1 = MEM forces the signed-word read control.
- bit_sucio_i  in  1  dirty flag for the current debug address; valid in the same cycle the address is driven.
- data_mem_debug_unit_i  in  NB_DATA  memory read data; valid one cycle after the address is driven.
- tx_data_o  out  NB_BYTE  byte to transmit.
- tx_start_o  out  1  one-cycle pulse; UART latches tx_data_o.
- tx_done_i  in  1  one-cycle pulse from the UART when the byte has been sent.
- busy_o  out  1  high from the cycle after an accepted start_i until DONE.
- done_o  out  1  one-cycle pulse when the terminator transmission completes.

Behaviour:
- Reset (asynchronous, reset_i=1): state=IDLE and all counters cleared. All outputs are 0, including addr_mem_debug_unit_o and tx_data_o.
- A reset mid-dump aborts immediately. A TX byte already in flight is not waited for.
- cntl_addr_debug_mem_o and cntl_wr_debug_mem_o equal busy_o, and are registered.
- States: IDLE, CHECK, READ, LOAD, WAIT_TX, NEXT, SEND_END, WAIT_END, DONE.
- IDLE: when start_i=1, clear the address counter to 0 and go to CHECK.
- CHECK: addr_mem_debug_unit_o=addr.
  - bit_sucio_i=1 → READ.
  - bit_sucio_i=0 → NEXT.
- READ: hold the address for one cycle. Then capture data_mem_debug_unit_i into the word register, clear byte_idx to 0, and go to LOAD.
- LOAD: drive tx_data_o from the frame, pulse tx_start_o for exactly one cycle, then go to WAIT_TX.
  - byte_idx 0: address byte {(8-NB_ADDR) zeros, addr}.
  - byte_idx 1..4: word bits [31:24], [23:16], [15:8], [7:0] (MSB first).
- WAIT_TX: hold tx_data_o until tx_done_i.
  - On tx_done_i, if byte_idx=4 → NEXT.
  - Otherwise byte_idx+1 → LOAD.
- NEXT:
  - If addr=2^NB_ADDR−1 → SEND_END.
  - Otherwise addr+1 → CHECK.
  - The address counter never wraps during a dump.
- SEND_END: tx_data_o=END_BYTE, pulse tx_start_o, → WAIT_END.
- WAIT_END: on tx_done_i → DONE.
- DONE: done_o=1 for one cycle, busy_o drops, → IDLE.
- start_i while busy is ignored, with no restart and no queueing.
- tx_done_i outside WAIT_TX/WAIT_END is ignored.
- A tx_done_i in the same cycle as the tx_start_o pulse is not counted. The UART reports done no earlier than the next cycle.
- Minimum cost per address: clean = 2 cycles (CHECK, NEXT). Dirty = 3 cycles plus 5 UART transmissions.
- No dirty words: the output is the terminator alone.

Decomposition:
- Shared package additions (parameters.vh):
  - State encodings for the dump FSM.
  - END_BYTE.
  - FRAME_BYTES=5.
- One natural sub-module, frame_byte_sel: a combinational mux selecting the frame byte from byte_idx, addr and the word register.
- The FSM, counters and registers stay in mem_dump_unit.

Test Plan:
- No writes since reset, then start_i → only 0xFF sent; done_o pulses; busy_o low afterwards. Verify for NB_ADDR=5 that exactly 2×32 cycles elapse before SEND_END, with a zero-latency UART model.
- Dirty addr 3 = 0xDEADBEEF → bytes 0x03, 0xDE, 0xAD, 0xBE, 0xEF, 0xFF. Each tx_start_o is a one-cycle pulse.
- Dirty addr 0 = 0x00000001 and addr 31 = 0x80000000 → 0x00,0x00,0x00,0x00,0x01, then 0x1F,0x80,0x00,0x00,0x00, then 0xFF. Covers the first and last address, with no wrap.
- UART done delayed 20 cycles → tx_data_o is stable throughout; a second start_i mid-dump causes no restart.
- reset_i asserted mid-frame → all outputs 0 at once. A new start_i then yields a complete, correct dump.
- cntl_addr_debug_mem_o and cntl_wr_debug_mem_o are 1 exactly while busy_o=1, and 0 in IDLE.

Source files
------------

// File: rtl/mem_dump_unit_pkg.sv
// Shared constants and FSM encoding for the data-memory dump sequencer.
package mem_dump_unit_pkg;

  localparam int NB_DATA     = 32;
  localparam int NB_BYTE     = 8;
  // Data-memory address width; kept <= 7 so END_BYTE never looks like an address byte.
  localparam int ADDR_W      = 5;
  localparam int FRAME_BYTES = 5;
  localparam logic [NB_BYTE-1:0] END_BYTE = 8'hFF;
  localparam logic [2:0] BIDX_LAST = 3'(FRAME_BYTES - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHECK    = 4'd1,
    ST_READ     = 4'd2,
    ST_LOAD     = 4'd3,
    ST_WAIT_TX  = 4'd4,
    ST_NEXT     = 4'd5,
    ST_SEND_END = 4'd6,
    ST_WAIT_END = 4'd7,
    ST_DONE     = 4'd8
  } dump_state_t;

endpackage

// File: rtl/mem_dump_unit_if.sv
// Bundle between the dump sequencer, the MEM debug port and the UART TX.
interface mem_dump_unit_if
  import mem_dump_unit_pkg::*;
#(
  parameter int NB_ADDR = ADDR_W
);
  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic [NB_ADDR-1:0] addr_mem_debug_unit_o;
  logic               cntl_addr_debug_mem_o;
  logic               cntl_wr_debug_mem_o;
  logic               bit_sucio_i;
  logic [NB_DATA-1:0] data_mem_debug_unit_i;
  logic [NB_BYTE-1:0] tx_data_o;
  logic               tx_start_o;
  logic               tx_done_i;

  modport slave (
    input  start_i, bit_sucio_i, data_mem_debug_unit_i, tx_done_i,
    output busy_o, done_o, addr_mem_debug_unit_o, cntl_addr_debug_mem_o,
           cntl_wr_debug_mem_o, tx_data_o, tx_start_o
  );

  modport master (
    output start_i, bit_sucio_i, data_mem_debug_unit_i, tx_done_i,
    input  busy_o, done_o, addr_mem_debug_unit_o, cntl_addr_debug_mem_o,
           cntl_wr_debug_mem_o, tx_data_o, tx_start_o
  );

endinterface

// File: rtl/mem_dump_unit_frame_byte_sel.sv
// Picks one byte of the 5-byte dump frame: address byte, then the word MSB first.
module mem_dump_unit_frame_byte_sel
  import mem_dump_unit_pkg::*;
#(
  parameter int NB_ADDR = ADDR_W
)(
  input  logic [2:0]         byte_idx,
  input  logic [NB_ADDR-1:0] addr,
  input  logic [NB_DATA-1:0] word,
  output logic [NB_BYTE-1:0] frame_byte
);

  always_comb begin
    frame_byte = word[7:0];
    case (byte_idx)
      3'd0:    frame_byte = {{(NB_BYTE-NB_ADDR){1'b0}}, addr};
      3'd1:    frame_byte = word[31:24];
      3'd2:    frame_byte = word[23:16];
      3'd3:    frame_byte = word[15:8];
      default: frame_byte = word[7:0];
    endcase
  end

endmodule

// File: rtl/mem_dump_unit.sv
// Walks data memory through the MEM debug mux and streams dirty words to the UART,
// closing with END_BYTE. Only safe while the pipeline is halted.
module mem_dump_unit
  import mem_dump_unit_pkg::*;
#(
  parameter int NB_ADDR = ADDR_W
)(
  input  logic           clock_i,
  input  logic           reset_i,
  mem_dump_unit_if.slave bus
);

  dump_state_t        state, state_nxt;
  logic [NB_ADDR-1:0] addr, addr_nxt;
  logic [2:0]         bidx, bidx_nxt;
  logic [NB_DATA-1:0] word, word_nxt;
  logic [NB_BYTE-1:0] frame_byte;
  logic [NB_BYTE-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               done_q;

  // Fed with next-cycle values so tx_data_o is already valid in the LOAD cycle.
  mem_dump_unit_frame_byte_sel #(.NB_ADDR(NB_ADDR)) u_sel (
    .byte_idx   (bidx_nxt),
    .addr       (addr_nxt),
    .word       (word_nxt),
    .frame_byte (frame_byte)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    bidx_nxt  = bidx;
    word_nxt  = word;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          addr_nxt  = '0;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK:    state_nxt = bus.bit_sucio_i ? ST_READ : ST_NEXT;
      ST_READ: begin
        word_nxt  = bus.data_mem_debug_unit_i;
        bidx_nxt  = '0;
        state_nxt = ST_LOAD;
      end
      ST_LOAD:     state_nxt = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (bus.tx_done_i) begin
          if (bidx == BIDX_LAST) begin
            state_nxt = ST_NEXT;
          end else begin
            bidx_nxt  = bidx + 3'd1;
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_NEXT: begin
        // Last address goes straight to the terminator; the counter never wraps.
        if (addr == '1) begin
          state_nxt = ST_SEND_END;
        end else begin
          addr_nxt  = addr + NB_ADDR'(1);
          state_nxt = ST_CHECK;
        end
      end
      ST_SEND_END: state_nxt = ST_WAIT_END;
      ST_WAIT_END: if (bus.tx_done_i) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      addr       <= '0;
      bidx       <= '0;
      word       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      bidx       <= bidx_nxt;
      word       <= word_nxt;
      tx_start_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_SEND_END);
      busy_q     <= !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
      done_q     <= (state_nxt == ST_DONE);
      if (state_nxt == ST_LOAD)
        tx_data_q <= frame_byte;
      else if (state_nxt == ST_SEND_END)
        tx_data_q <= END_BYTE;
    end
  end

  assign bus.addr_mem_debug_unit_o = addr;
  assign bus.cntl_addr_debug_mem_o = busy_q;
  assign bus.cntl_wr_debug_mem_o   = busy_q;
  assign bus.busy_o                = busy_q;
  assign bus.done_o                = done_q;
  assign bus.tx_data_o             = tx_data_q;
  assign bus.tx_start_o            = tx_start_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: memory/UART models plus a vector table of dumps.
module tb_mem_dump_unit;

  logic clock_i = 1'b0;
  logic reset_i;

  mem_dump_unit_if #(.NB_ADDR(5)) bus ();

  mem_dump_unit #(.NB_ADDR(5)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial forever #5 clock_i = ~clock_i;

  typedef struct {
    int              n_dirty;
    logic [4:0]      a0;
    logic [31:0]     d0;
    logic [4:0]      a1;
    logic [31:0]     d1;
    int              dly;
    int              restart_at;
    int              n_bytes;
    logic [0:10][7:0] exp;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] mem [32];
  logic [31:0] dirty;
  logic [7:0]  rx_q [$];
  int          uart_dly;
  int          cnt;
  logic [7:0]  rec;
  logic        prev_start;
  int          stab_err, pulse_err, cntl_err;

  // Memory: dirty flag combinational on the address, data one cycle later.
  assign bus.bit_sucio_i = dirty[bus.addr_mem_debug_unit_o];
  always @(posedge clock_i) bus.data_mem_debug_unit_i <= mem[bus.addr_mem_debug_unit_o];

  // UART model: done arrives uart_dly cycles after the start pulse; data must hold meanwhile.
  always @(negedge clock_i) begin
    if (reset_i) begin
      bus.tx_done_i = 1'b0;
      cnt = 0;
      prev_start = 1'b0;
    end else begin
      bus.tx_done_i = 1'b0;
      if (cnt > 0) begin
        if (bus.tx_data_o !== rec) stab_err++;
        cnt--;
        if (cnt == 0) bus.tx_done_i = 1'b1;
      end
      if (bus.tx_start_o) begin
        if (prev_start) pulse_err++;
        rec = bus.tx_data_o;
        rx_q.push_back(bus.tx_data_o);
        cnt = uart_dly;
      end
      prev_start = bus.tx_start_o;
    end
    if (bus.cntl_addr_debug_mem_o !== bus.busy_o || bus.cntl_wr_debug_mem_o !== bus.busy_o)
      cntl_err++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    dirty = 32'h0;
    if (v.n_dirty > 0) begin mem[v.a0] = v.d0; dirty[v.a0] = 1'b1; end
    if (v.n_dirty > 1) begin mem[v.a1] = v.d1; dirty[v.a1] = 1'b1; end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    stab_err = 0; pulse_err = 0; cntl_err = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    load_mem(v);
    clear_obs();
    uart_dly = v.dly;
    @(negedge clock_i); bus.start_i = 1'b1;
    @(negedge clock_i); bus.start_i = 1'b0;
    chk({tag, "_busy_rise"}, {bus.busy_o, bus.cntl_addr_debug_mem_o}, 2'b11);
    n = 1;
    if (v.restart_at > 0) begin
      while (n < v.restart_at) begin @(negedge clock_i); n++; end
      bus.start_i = 1'b1;
      @(negedge clock_i); bus.start_i = 1'b0; n++;
    end
    while (!bus.done_o && n < 3000) begin @(negedge clock_i); n++; end
    chk({tag, "_done"}, bus.done_o, 1'b1);
    @(negedge clock_i);
    chk({tag, "_idle_after"}, {bus.busy_o, bus.done_o, bus.cntl_wr_debug_mem_o}, 3'b000);
    chk({tag, "_cntl_eq_busy"}, cntl_err, 0);
    chk({tag, "_start_pulse"}, pulse_err, 0);
    chk({tag, "_data_stable"}, stab_err, 0);
    chk({tag, "_nbytes"}, rx_q.size(), v.n_bytes);
    for (int i = 0; i < v.n_bytes; i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, v.exp[i]);
  endtask

  vec_t vt [4];

  initial begin
    vec_t v;
    int   n;
    vt[0] = '{0, 5'd0, 32'h0, 5'd0, 32'h0, 1, 0, 1, {8'hFF, 80'h0}};
    vt[1] = '{1, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 1, 0, 6,
              {8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 40'h0}};
    vt[2] = '{2, 5'd0, 32'h00000001, 5'd31, 32'h80000000, 1, 0, 11,
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h1F, 8'h80, 8'h00, 8'h00, 8'h00, 8'hFF}};
    vt[3] = '{1, 5'd10, 32'h12345678, 5'd0, 32'h0, 20, 30, 6,
              {8'h0A, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 40'h0}};

    reset_i = 1'b1;
    bus.start_i = 1'b0;
    uart_dly = 1;
    load_mem(vt[0]);
    clear_obs();
    repeat (2) @(negedge clock_i);
    chk("reset_ctrl", {bus.busy_o, bus.done_o, bus.tx_start_o,
                       bus.cntl_addr_debug_mem_o, bus.cntl_wr_debug_mem_o}, 5'b0);
    chk("reset_addr", bus.addr_mem_debug_unit_o, 5'd0);
    chk("reset_txdata", bus.tx_data_o, 8'h00);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("idle_no_start", {bus.busy_o, bus.tx_start_o}, 2'b00);

    for (int k = 0; k < 4; k++) run_vec(vt[k], $sformatf("vec%0d", k));

    // Clean walk timing: 2 cycles per address before the terminator.
    load_mem(vt[0]);
    clear_obs();
    uart_dly = 1;
    @(negedge clock_i); bus.start_i = 1'b1;
    @(negedge clock_i); bus.start_i = 1'b0;
    n = 1;
    while (!bus.tx_start_o && n < 500) begin @(negedge clock_i); n++; end
    chk("clean_walk_cycles", n - 1, 64);
    chk("clean_walk_end_byte", bus.tx_data_o, 8'hFF);
    n = 0;
    while (!bus.done_o && n < 500) begin @(negedge clock_i); n++; end
    chk("clean_walk_done", bus.done_o, 1'b1);

    // Reset in the middle of a frame, then a full dump from scratch.
    v = vt[1];
    v.dly = 20;
    load_mem(v);
    clear_obs();
    uart_dly = 20;
    @(negedge clock_i); bus.start_i = 1'b1;
    @(negedge clock_i); bus.start_i = 1'b0;
    n = 0;
    while (rx_q.size() < 2 && n < 2000) begin @(negedge clock_i); n++; end
    chk("rst_reached_frame", rx_q.size(), 2);
    #1 reset_i = 1'b1;
    #1;
    chk("midrst_ctrl", {bus.busy_o, bus.done_o, bus.tx_start_o,
                        bus.cntl_addr_debug_mem_o, bus.cntl_wr_debug_mem_o}, 5'b0);
    chk("midrst_data", {bus.addr_mem_debug_unit_o, bus.tx_data_o}, 13'h0);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    run_vec(vt[1], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
